// File: rtl/resizer_pkg.sv
// Shared definitions for the resizer output path.
//
// Contents:
//   KEEP_BIT / STRB_BIT  lane field offsets, counted down from the lane width:
//                        keep sits at bit LANE_SZ-KEEP_BIT, strb at LANE_SZ-STRB_BIT,
//                        data occupies bits T_DATA_WIDTH-1:0.
//   lane_sz()            LANE_SZ formula.
//   buf_out_entry_sz()   BUF_OUT_ENTRY_SZ formula.
//   out_beat_t           packed {data, keep, strb, last} record for the default geometry.
//   unpack_entry()       splits a default-geometry packed entry into an out_beat_t.
package resizer_pkg;

    localparam int unsigned KEEP_BIT = 1;
    localparam int unsigned STRB_BIT = 2;

    function automatic int unsigned lane_sz(input int unsigned t_data_width);
        return t_data_width + 2;
    endfunction

    function automatic int unsigned buf_out_entry_sz(input int unsigned t_data_width,
                                                     input int unsigned m_keep_width);
        return lane_sz(t_data_width) * m_keep_width;
    endfunction

    // Default geometry of the resizer output.
    localparam int unsigned DEF_T_DATA_WIDTH     = 1;
    localparam int unsigned DEF_M_KEEP_WIDTH     = 2;
    localparam int unsigned DEF_LANE_SZ          = lane_sz(DEF_T_DATA_WIDTH);
    localparam int unsigned DEF_BUF_OUT_ENTRY_SZ =
        buf_out_entry_sz(DEF_T_DATA_WIDTH, DEF_M_KEEP_WIDTH);

    typedef struct packed {
        logic [DEF_M_KEEP_WIDTH*DEF_T_DATA_WIDTH-1:0] data;
        logic [DEF_M_KEEP_WIDTH-1:0]                  keep;
        logic [DEF_M_KEEP_WIDTH-1:0]                  strb;
        logic                                         last;
    } out_beat_t;

    function automatic out_beat_t unpack_entry(input logic [DEF_BUF_OUT_ENTRY_SZ-1:0] entry,
                                               input logic                            last);
        out_beat_t b;
        b = '0;
        for (int i = 0; i < int'(DEF_M_KEEP_WIDTH); i++) begin
            b.data[i*DEF_T_DATA_WIDTH +: DEF_T_DATA_WIDTH] =
                entry[i*DEF_LANE_SZ +: DEF_T_DATA_WIDTH];
            b.keep[i] = entry[i*DEF_LANE_SZ + DEF_LANE_SZ - KEEP_BIT];
            b.strb[i] = entry[i*DEF_LANE_SZ + DEF_LANE_SZ - STRB_BIT];
        end
        b.last = last;
        return b;
    endfunction

endpackage

// File: rtl/axis_master_port_if.sv
// Bundle between the width-conversion buffer, the output port and the AXI-Stream sink.
//
// Signals:
//   master_entry        packed entry from the buffer (valid one cycle after a request)
//   underflow           buffer empty; a request issued while high returns nothing
//   master_entry_ready  read request to the buffer
//   m_axis_*            AXI-Stream master channel (tvalid/tready/tdata/tkeep/tstrb/tlast)
//   null_drop           one-cycle pulse when an all-null entry is discarded
//
// Modports: master = the port itself, slave = its environment (buffer + sink).
interface axis_master_port_if
    import resizer_pkg::*;
#(
    parameter int unsigned T_DATA_WIDTH = 1,
    parameter int unsigned M_KEEP_WIDTH = 2
) ();

    localparam int unsigned ENTRY_SZ = buf_out_entry_sz(T_DATA_WIDTH, M_KEEP_WIDTH);

    logic [ENTRY_SZ-1:0]                  master_entry;
    logic                                 underflow;
    logic                                 master_entry_ready;
    logic                                 m_axis_tvalid;
    logic                                 m_axis_tready;
    logic [M_KEEP_WIDTH*T_DATA_WIDTH-1:0] m_axis_tdata;
    logic [M_KEEP_WIDTH-1:0]              m_axis_tkeep;
    logic [M_KEEP_WIDTH-1:0]              m_axis_tstrb;
    logic                                 m_axis_tlast;
    logic                                 null_drop;

    modport master (
        input  master_entry,
        input  underflow,
        input  m_axis_tready,
        output master_entry_ready,
        output m_axis_tvalid,
        output m_axis_tdata,
        output m_axis_tkeep,
        output m_axis_tstrb,
        output m_axis_tlast,
        output null_drop
    );

    modport slave (
        output master_entry,
        output underflow,
        output m_axis_tready,
        input  master_entry_ready,
        input  m_axis_tvalid,
        input  m_axis_tdata,
        input  m_axis_tkeep,
        input  m_axis_tstrb,
        input  m_axis_tlast,
        input  null_drop
    );

endinterface

// File: rtl/entry_fifo.sv
// Register FIFO of output beats used as the skid buffer of axis_master_port.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push       write push_beat at the tail
//   push_beat  beat to write
//   pop        remove the head (ignored when empty)
//   head       current head entry (meaningful only while count != 0)
//   count      number of stored entries
module entry_fifo
    import resizer_pkg::*;
#(
    parameter int unsigned DEPTH  = 3,
    parameter type         beat_t = out_beat_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  beat_t                      push_beat,
    input  logic                       pop,
    output beat_t                      head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    beat_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_eff;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign pop_eff = pop && (count_q != '0);

    always_comb begin
        wr_ptr_d = push    ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_eff ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop_eff) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop_eff) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing reads it while count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_beat;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // The upstream credit scheme must never let a write land in a full FIFO.
    push_not_full: assert property (@(posedge clk) disable iff (rst)
        push |-> (count_q != CNT_W'(DEPTH)));

endmodule

// File: rtl/axis_master_port.sv
// Output stage of the resizer. Requests packed entries from the width-conversion buffer,
// absorbs its one-cycle read latency in a skid FIFO, drops all-null entries, generates
// tlast and drives an AXI-Stream master.
//
// Ports:
//   clk   clock (rising edge)
//   rst   asynchronous active-high reset
//   bus   axis_master_port_if.master: buffer request/entry, m_axis_* channel, null_drop
//
// Parameters:
//   T_DATA_WIDTH  data bits per lane
//   M_KEEP_WIDTH  lanes per output beat
//   FIFO_DEPTH    skid FIFO entries (>= 3 for full throughput)
//   MAX_BEATS     forced packet length; tlast on every MAX_BEATS-th forwarded beat (>= 1)
module axis_master_port
    import resizer_pkg::*;
#(
    parameter int unsigned T_DATA_WIDTH = 1,
    parameter int unsigned M_KEEP_WIDTH = 2,
    parameter int unsigned FIFO_DEPTH   = 3,
    parameter int unsigned MAX_BEATS    = 16
) (
    input logic                clk,
    input logic                rst,
    axis_master_port_if.master bus
);

    localparam int unsigned LANE_SZ          = lane_sz(T_DATA_WIDTH);
    localparam int unsigned BUF_OUT_ENTRY_SZ = buf_out_entry_sz(T_DATA_WIDTH, M_KEEP_WIDTH);
    localparam int unsigned DATA_W           = M_KEEP_WIDTH * T_DATA_WIDTH;
    localparam int unsigned CNT_W            = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BEAT_W           = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    typedef struct packed {
        logic [DATA_W-1:0]       data;
        logic [M_KEEP_WIDTH-1:0] keep;
        logic [M_KEEP_WIDTH-1:0] strb;
        logic                    last;
    } beat_t;

    logic [BUF_OUT_ENTRY_SZ-1:0] entry;
    logic                        inflight_q, inflight_d;
    logic [BEAT_W-1:0]           beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]            fifo_count;
    logic                        credit_ok;
    logic                        entry_ready;
    logic                        all_null;
    logic                        push;
    logic                        pop;
    logic                        tvalid;
    beat_t                       cap_beat;
    beat_t                       head;

    assign entry = bus.master_entry;

    // ---------------------------------------------------------------------------------
    // Request credit: every outstanding request owns a FIFO slot, so a returning entry
    // always fits. Only registered state feeds this; rst merely holds it low in reset.
    // ---------------------------------------------------------------------------------
    assign credit_ok   = (32'(fifo_count) + 32'(inflight_q)) < FIFO_DEPTH;
    assign entry_ready = credit_ok && !rst;
    assign inflight_d  = entry_ready && !bus.underflow;

    // ---------------------------------------------------------------------------------
    // Capture and unpack of the returning entry.
    // ---------------------------------------------------------------------------------
    always_comb begin
        cap_beat = '0;
        for (int i = 0; i < int'(M_KEEP_WIDTH); i++) begin
            cap_beat.data[i*T_DATA_WIDTH +: T_DATA_WIDTH] =
                entry[i*LANE_SZ +: T_DATA_WIDTH];
            cap_beat.keep[i] = entry[i*LANE_SZ + LANE_SZ - KEEP_BIT];
            cap_beat.strb[i] = entry[i*LANE_SZ + LANE_SZ - STRB_BIT];
        end
        // A missing top lane marks a short (final) beat; otherwise cut at MAX_BEATS.
        cap_beat.last = !cap_beat.keep[M_KEEP_WIDTH-1]
                        || (beat_cnt_q == BEAT_W'(MAX_BEATS - 1));
    end

    assign all_null = (cap_beat.keep == '0);
    assign push     = inflight_q && !all_null;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (push) begin
            beat_cnt_d = cap_beat.last ? '0 : beat_cnt_q + BEAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // ---------------------------------------------------------------------------------
    // Skid FIFO and AXI-Stream output.
    // ---------------------------------------------------------------------------------
    assign tvalid = (fifo_count != '0);
    assign pop    = tvalid && bus.m_axis_tready;

    entry_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .beat_t (beat_t)
    ) u_entry_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_beat (cap_beat),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    // Payload is forced to zero while idle so the outputs are defined through reset; the
    // head cannot change while tvalid is high until it is popped.
    assign bus.master_entry_ready = entry_ready;
    assign bus.m_axis_tvalid      = tvalid;
    assign bus.m_axis_tdata       = tvalid ? head.data : '0;
    assign bus.m_axis_tkeep       = tvalid ? head.keep : '0;
    assign bus.m_axis_tstrb       = tvalid ? head.strb : '0;
    assign bus.m_axis_tlast       = tvalid && head.last;
    assign bus.null_drop          = inflight_q && all_null;

endmodule
